vedic_mul8_pipe: RTL and testbench

Pipelined, handshaked 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier. It sits directly downstream of the team's half-adder and 4/6/8/12-bit adder primitives: it builds four 4x4 partial products and combines them through those adder widths into a 16-bit product. It accepts one operand pair per cycle under valid/ready flow control, supports full backpressure, and collapses bubbles between stages.

---
 rtl/vedic_mul8_pipe_if.sv | 33 +++
 rtl/vedic_mul8_pipe.sv | 146 ++++++++++++++
 tb/tb_vedic_mul8_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vedic_mul8_pipe_if.sv
// vedic_mul8_pipe_if
//   Handshake bundle for the pipelined 8x8 Vedic multiplier.
//   Ports (all carried as interface signals):
//     in_valid  : producer presents an operand pair on a/b
//     in_ready  : multiplier accepts the pair this cycle
//     a, b      : 8-bit unsigned operands
//     out_valid : product on p is valid
//     out_ready : consumer accepts p this cycle
//     p         : 16-bit unsigned product
//     occ       : number of operand pairs held in the pipeline
//   Modports: master = producer/consumer side, slave = multiplier side.
interface vedic_mul8_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic [1:0]  occ;

  // The environment drives operands and consumer readiness.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, occ
  );

  // The multiplier drives acceptance, results and occupancy.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, occ
  );
endinterface

// File: rtl/vedic_mul8_pipe.sv
// vedic_mul8_pipe
//   Pipelined, valid/ready handshaked 8x8 unsigned Urdhva-Tiryagbhyam multiplier.
//   Four 4x4 partial products (each built from 2x2 Vedic cells) are combined
//   through a 12-bit and a 16-bit adder into the 16-bit product.
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : vedic_mul8_pipe_if.slave (in_valid/in_ready/a/b,
//             out_valid/out_ready/p, occ)
//   Configuration macro VEDIC_MUL8_PPREG_EN:
//     defined   -> partial products are registered (3 stages, latency 3)
//     undefined -> partial products feed the output stage directly
//                  (2 stages, latency 2)
module vedic_mul8_pipe (
  input  logic              clk,
  input  logic              rst_n,
  vedic_mul8_pipe_if.slave  bus
);

  // 2x2 Vedic cell: vertical and crosswise terms merged with half adders.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic c1;
    logic [3:0] r;
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  // 4x4 Vedic product from four 2x2 cells; the crosswise sum keeps its carry.
  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] t0, t1, t2, t3;
    logic [5:0] mid;
    t0  = vedic2(x[1:0], y[1:0]);
    t1  = vedic2(x[3:2], y[1:0]);
    t2  = vedic2(x[1:0], y[3:2]);
    t3  = vedic2(x[3:2], y[3:2]);
    mid = {2'b00, t1} + {2'b00, t2};
    return {t3, t0} + {mid, 2'b00};
  endfunction

  logic        r_v1, r_v3;
  logic [7:0]  r_a1, r_b1;
  logic [15:0] r_p3;
  logic        w_rdy1, w_rdy3;
  logic [7:0]  w_q0, w_q1, w_q2, w_q3;
  logic        w_vs;
  logic [7:0]  w_s0, w_s1, w_s2, w_s3;
  logic [11:0] w_m;
  logic [15:0] w_p;

  // Partial products always come straight from the operand register.
  assign w_q0 = vedic4(r_a1[3:0], r_b1[3:0]);
  assign w_q1 = vedic4(r_a1[7:4], r_b1[3:0]);
  assign w_q2 = vedic4(r_a1[3:0], r_b1[7:4]);
  assign w_q3 = vedic4(r_a1[7:4], r_b1[7:4]);

  // A stage may load when it is empty or its successor is moving on,
  // so bubbles are squeezed out even while the consumer stalls.
  assign w_rdy3 = !r_v3 | bus.out_ready;

`ifdef VEDIC_MUL8_PPREG_EN
  logic       r_v2;
  logic [7:0] r_q0, r_q1, r_q2, r_q3;
  logic       w_rdy2;

  assign w_rdy2 = !r_v2 | w_rdy3;
  assign w_rdy1 = !r_v1 | w_rdy2;

  // Partial-product register stage: valid follows upstream whenever the
  // stage advances, data only captures a real operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_q0 <= 8'd0;
      r_q1 <= 8'd0;
      r_q2 <= 8'd0;
      r_q3 <= 8'd0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q0 <= w_q0;
        r_q1 <= w_q1;
        r_q2 <= w_q2;
        r_q3 <= w_q3;
      end
    end
  end

  assign w_vs = r_v2;
  assign w_s0 = r_q0;
  assign w_s1 = r_q1;
  assign w_s2 = r_q2;
  assign w_s3 = r_q3;
  assign bus.occ = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3};
`else
  assign w_rdy1 = !r_v1 | w_rdy3;
  assign w_vs   = r_v1;
  assign w_s0   = w_q0;
  assign w_s1   = w_q1;
  assign w_s2   = w_q2;
  assign w_s3   = w_q3;
  assign bus.occ = {1'b0, r_v1} + {1'b0, r_v3};
`endif

  // Combine: the crosswise pair is summed at 12 bits so its carry survives,
  // then shifted by one nibble onto the concatenated outer products.
  assign w_m = {4'b0000, w_s1} + {4'b0000, w_s2};
  assign w_p = {w_s3, w_s0} + {w_m, 4'b0000};

  // Operand register stage: captures a/b only on a real handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a1 <= 8'd0;
      r_b1 <= 8'd0;
    end else if (w_rdy1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_a1 <= bus.a;
        r_b1 <= bus.b;
      end
    end
  end

  // Output register stage: p only changes when the stage advances with a
  // valid product, so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      r_p3 <= 16'd0;
    end else if (w_rdy3) begin
      r_v3 <= w_vs;
      if (w_vs) begin
        r_p3 <= w_p;
      end
    end
  end

  assign bus.in_ready  = w_rdy1;
  assign bus.out_valid = r_v3;
  assign bus.p         = r_p3;

endmodule

// File: tb/tb_vedic_mul8_pipe.sv
// tb_vedic_mul8_pipe
//   Self-checking bench for vedic_mul8_pipe. A behavioural model holds the
//   in-flight products as a queue with the number of edges each has spent
//   inside; the oldest one is presented once it has aged through the pipe.
module tb_vedic_mul8_pipe;

`ifdef VEDIC_MUL8_PPREG_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic clk;
  logic rst_n;
  vedic_mul8_pipe_if bus ();

  vedic_mul8_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp;
  int n_fail;

  logic [15:0] m_prod[$];
  int          m_age[$];

  logic        exp_ready, exp_valid;
  logic [15:0] exp_p;
  logic [1:0]  exp_occ;
  logic        obs_ready, obs_valid;
  logic [15:0] obs_p;
  logic [1:0]  obs_occ;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: drive inputs just after an edge, predict and sample the
  // outputs before the next edge, then advance the model across the edge.
  task automatic drive_cycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                             input logic ordy);
    bus.in_valid  = v;
    bus.a         = ia;
    bus.b         = ib;
    bus.out_ready = ordy;
    exp_occ   = 2'(m_prod.size());
    exp_ready = (m_prod.size() < DEPTH) || ordy;
    exp_valid = (m_prod.size() > 0) && (m_age[0] >= DEPTH - 1);
    exp_p     = exp_valid ? m_prod[0] : 16'd0;
    #1;
    obs_ready = bus.in_ready;
    obs_valid = bus.out_valid;
    obs_p     = bus.p;
    obs_occ   = bus.occ;
    @(posedge clk);
    if (exp_valid && ordy) begin
      void'(m_prod.pop_front());
      void'(m_age.pop_front());
    end
    foreach (m_age[i]) m_age[i] = m_age[i] + 1;
    if (v && exp_ready) begin
      m_prod.push_back(16'(ia) * 16'(ib));
      m_age.push_back(0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.p !== 16'd0) begin n_fail++; $display("FAIL reset_p: got %h want 0000", bus.p); end
    n_cmp++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", bus.occ); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_op();
    drive_cycle(1'b1, 8'd13, 8'd11, 1'b1);
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", obs_ready); end
    for (int k = 1; k <= DEPTH + 2; k++) begin
      drive_cycle(1'b0, 8'd0, 8'd0, 1'b1);
      n_cmp++; if (obs_valid !== (k == DEPTH)) begin n_fail++; $display("FAIL single_valid_c%0d: got %b want %b", k, obs_valid, (k == DEPTH)); end
      if (k == DEPTH) begin
        n_cmp++; if (obs_p !== 16'h008F) begin n_fail++; $display("FAIL single_p: got %h want 008f", obs_p); end
      end
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ca[4];
    logic [7:0]  cb[4];
    logic [15:0] cp[4];
    ca = '{8'd255, 8'd0, 8'd16, 8'd255};
    cb = '{8'd255, 8'd200, 8'd16, 8'd1};
    cp = '{16'hFE01, 16'h0000, 16'h0100, 16'h00FF};
    for (int c = 0; c < DEPTH + 6; c++) begin
      if (c < 4) drive_cycle(1'b1, ca[c], cb[c], 1'b1);
      else       drive_cycle(1'b0, 8'd0, 8'd0, 1'b1);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL corner_ready_c%0d: got %b want 1", c, obs_ready); end
      n_cmp++; if (obs_valid !== (c >= DEPTH && c < DEPTH + 4)) begin n_fail++; $display("FAIL corner_valid_c%0d: got %b", c, obs_valid); end
      if (c >= DEPTH && c < DEPTH + 4) begin
        n_cmp++; if (obs_p !== cp[c - DEPTH]) begin n_fail++; $display("FAIL corner_p_%0d: got %h want %h", c - DEPTH, obs_p, cp[c - DEPTH]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa[5];
    logic [7:0] pb[5];
    int idx;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    for (int c = 0; c < 30; c++) begin
      drive_cycle(idx < 5, pa[idx % 5], pb[idx % 5], c >= 8);
      if (idx < 5 && exp_ready) idx++;
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want %b", c, obs_ready, exp_ready); end
      n_cmp++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL bp_occ_c%0d: got %0d want %0d", c, obs_occ, exp_occ); end
      n_cmp++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want %b", c, obs_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL bp_p_c%0d: got %h want %h", c, obs_p, exp_p); end
      end
      if (c == 7) begin
        n_cmp++; if (obs_occ !== 2'(DEPTH)) begin n_fail++; $display("FAIL bp_full_occ: got %0d want %0d", obs_occ, DEPTH); end
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", obs_ready); end
      end
    end
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", obs_valid); end
  endtask

  task automatic test_bubble();
    logic [7:0] xa, xb;
    xa = 8'($urandom); xb = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive_cycle(1'b1, xa, xb, 1'b0);
      else if (c == 2) drive_cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      else             drive_cycle(1'b0, 8'd0, 8'd0, 1'b0);
      n_cmp++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL bubble_occ_c%0d: got %0d want %0d", c, obs_occ, exp_occ); end
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL bubble_ready_c%0d: got %b want %b", c, obs_ready, exp_ready); end
    end
    n_cmp++; if (obs_occ !== 2'd2) begin n_fail++; $display("FAIL bubble_final_occ: got %0d want 2", obs_occ); end
    n_cmp++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_final_valid: got %b want 1", obs_valid); end
    n_cmp++; if (obs_p !== 16'(xa) * 16'(xb)) begin n_fail++; $display("FAIL bubble_final_p: got %h want %h", obs_p, 16'(xa) * 16'(xb)); end
    for (int c = 0; c < DEPTH + 4; c++) begin
      drive_cycle(1'b0, 8'd0, 8'd0, 1'b1);
      n_cmp++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL bubble_drain_valid_c%0d: got %b want %b", c, obs_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL bubble_drain_p_c%0d: got %h want %h", c, obs_p, exp_p); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < DEPTH + 1; c++) drive_cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    #1;
    n_cmp++; if (bus.occ !== 2'(DEPTH)) begin n_fail++; $display("FAIL midrst_pre_occ: got %0d want %0d", bus.occ, DEPTH); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d want 0", bus.occ); end
    n_cmp++; if (bus.p !== 16'd0) begin n_fail++; $display("FAIL midrst_p: got %h want 0000", bus.p); end
    m_prod.delete();
    m_age.delete();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < DEPTH + 3; c++) begin
      drive_cycle(1'b0, 8'd0, 8'd0, 1'b1);
      n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_c%0d: got %b want 0", c, obs_valid); end
    end
  endtask

  task automatic test_random();
    int accepted;
    int cyc;
    accepted = 0;
    cyc = 0;
    while ((accepted < 10000 || m_prod.size() > 0) && cyc < 60000) begin
      drive_cycle((accepted < 10000) && ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 6);
      if (bus.in_valid && exp_ready) accepted++;
      cyc++;
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", cyc, obs_ready, exp_ready); end
      n_cmp++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid_c%0d: got %b want %b", cyc, obs_valid, exp_valid); end
      n_cmp++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL rand_occ_c%0d: got %0d want %0d", cyc, obs_occ, exp_occ); end
      if (exp_valid) begin
        n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL rand_p_c%0d: got %h want %h", cyc, obs_p, exp_p); end
      end
    end
    n_cmp++; if (m_prod.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d pending want 0", m_prod.size()); end
  endtask

  // Scenarios run back to back; each leaves the pipeline drained.
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_op();
    test_corners();
    test_backpressure();
    test_bubble();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
